// File: rtl/dsram_arb_pkg.sv
// Shared definitions for the data-SRAM arbiter: owner-state encoding, the
// default address window base, and the request-to-SRAM address mapping.
package dsram_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_OWN_M0 = 2'd1;
    localparam logic [1:0] ST_OWN_M1 = 2'd2;

    localparam logic [31:0] DSRAM_ADDR_OFFSET = 32'hA000_0000;

    // The SRAM is word addressed in bytes: drop the byte lane, then rebase.
    function automatic logic [31:0] sram_word_addr(input logic [31:0] addr,
                                                   input logic [31:0] offset);
        return (addr & 32'hFFFF_FFFC) - offset;
    endfunction

endpackage

// File: rtl/dsram_arb_pick.sv
// Combinational winner selection between the CPU port (m0) and the DMA/debug
// port (m1). m0 wins by default; m1 wins when starved or while its lock lasts.
module dsram_arb_pick
    import dsram_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int LOCK_MAX = 8,
    parameter int WAIT_W   = 3,
    parameter int LOCK_W   = 4
) (
    input  logic              i_m0_req,
    input  logic              i_m1_req,
    input  logic              i_m1_lock,
    input  logic [1:0]        i_state,
    input  logic [WAIT_W-1:0] i_wait_cnt,
    input  logic [LOCK_W-1:0] i_lock_cnt,
    output logic              o_m0_gnt,
    output logic              o_m1_gnt
);

    logic w_starved;
    logic w_locked;

    assign w_starved = (i_wait_cnt == WAIT_W'(MAX_WAIT));
    // An exhausted lock falls back to default priority, so m0 gets its turn.
    assign w_locked  = (i_state == ST_OWN_M1) && i_m1_lock &&
                       (i_lock_cnt < LOCK_W'(LOCK_MAX));

    assign o_m1_gnt = i_m1_req && (!i_m0_req || w_starved || w_locked);
    assign o_m0_gnt = i_m0_req && !o_m1_gnt;

endmodule

// File: rtl/dsram_arb.sv
// Two-master arbiter in front of a single-port data SRAM: same-cycle grant,
// combinational SRAM drive, one-cycle read return routed to the requester.
module dsram_arb
    import dsram_arb_pkg::*;
#(
    parameter logic [31:0] ADDR_OFFSET = DSRAM_ADDR_OFFSET,
    parameter int          MAX_WAIT    = 4,
    parameter int          LOCK_MAX    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic        m1_wr,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a master's req is accepted in exactly the cycle its gnt is
    // high; a read returns on that master's rvalid the following cycle.

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int LOCK_W = $clog2(LOCK_MAX + 1);

    logic [1:0]        r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic              r_rd_m0;
    logic              r_rd_m1;

    logic w_pick_m0;
    logic w_pick_m1;
    logic w_m0_gnt;
    logic w_m1_gnt;

    dsram_arb_pick #(
        .MAX_WAIT (MAX_WAIT),
        .LOCK_MAX (LOCK_MAX),
        .WAIT_W   (WAIT_W),
        .LOCK_W   (LOCK_W)
    ) u_pick (
        .i_m0_req   (m0_req),
        .i_m1_req   (m1_req),
        .i_m1_lock  (m1_lock),
        .i_state    (r_state),
        .i_wait_cnt (r_wait_cnt),
        .i_lock_cnt (r_lock_cnt),
        .o_m0_gnt   (w_pick_m0),
        .o_m1_gnt   (w_pick_m1)
    );

    assign w_m0_gnt = w_pick_m0 && !rst;
    assign w_m1_gnt = w_pick_m1 && !rst;
    assign m0_gnt   = w_m0_gnt;
    assign m1_gnt   = w_m1_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_lock_cnt <= '0;
            r_rd_m0    <= 1'b0;
            r_rd_m1    <= 1'b0;
        end else begin
            if (w_m0_gnt)      r_state <= ST_OWN_M0;
            else if (w_m1_gnt) r_state <= ST_OWN_M1;
            else               r_state <= ST_IDLE;

            if (m1_req && !w_m1_gnt)
                r_wait_cnt <= (r_wait_cnt == WAIT_W'(MAX_WAIT)) ? r_wait_cnt
                                                                 : r_wait_cnt + 1'b1;
            else
                r_wait_cnt <= '0;

            if (w_m1_gnt && m1_lock)
                r_lock_cnt <= (r_lock_cnt == LOCK_W'(LOCK_MAX)) ? r_lock_cnt
                                                                 : r_lock_cnt + 1'b1;
            else
                r_lock_cnt <= '0;

            r_rd_m0 <= w_m0_gnt && !m0_wr;
            r_rd_m1 <= w_m1_gnt && !m1_wr;
        end
    end

    // A read granted just before reset must not surface while reset is held.
    assign m0_rvalid = r_rd_m0 && !rst;
    assign m1_rvalid = r_rd_m1 && !rst;
    assign m0_rdata  = m0_rvalid ? data_sram_rdata : 32'h0;
    assign m1_rdata  = m1_rvalid ? data_sram_rdata : 32'h0;

    always_comb begin
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'b0000;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        if (w_m0_gnt) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = m0_wr ? m0_be : 4'b0000;
            data_sram_addr  = sram_word_addr(m0_addr, ADDR_OFFSET);
            data_sram_wdata = m0_wdata;
        end else if (w_m1_gnt) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = m1_wr ? m1_be : 4'b0000;
            data_sram_addr  = sram_word_addr(m1_addr, ADDR_OFFSET);
            data_sram_wdata = m1_wdata;
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: doc/dsram_arb.md
DSRAM_ARB -- requirements
Module: dsram_arb

Interface
REQ-001 SHALL have parameter ADDR_OFFSET, default 32'hA000_0000: subtracted from the request address to form the SRAM address.
REQ-002 SHALL have parameter MAX_WAIT, default 4: the number of consecutive denied cycles for m1 before m1 is forced to win.
REQ-003 SHALL have parameter LOCK_MAX, default 8: the maximum number of consecutive m1 locked beats.
REQ-004 clk  in  1  sole clock; all state updates on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 m0_req  in  1  CPU MEM-stage access request.
REQ-007 m0_wr, m0_be, m0_addr, m0_wdata  in  1/4/32/32  write flag, byte enables, byte address, pre-replicated write data.
REQ-008 m0_gnt  out  1  m0 request accepted this cycle.
REQ-009 m0_rvalid, m0_rdata  out  1/32  read data for m0.
REQ-010 m1_req, m1_lock, m1_wr, m1_be, m1_addr, m1_wdata  in  1/1/1/4/32/32  the same fields for the DMA/debug port; m1_lock requests consecutive beats.
REQ-011 m1_gnt, m1_rvalid, m1_rdata  out  1/1/32  the same meaning as for m0.
REQ-012 data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata  out  1/4/32/32  SRAM port.
REQ-013 data_sram_rdata  in  32  SRAM read data, valid one cycle after an enabled read.

Function
REQ-014 Grant SHALL be combinational in the request cycle, with at most one of m0_gnt/m1_gnt high, and only for an asserted req.
REQ-015 Owner FSM states SHALL be IDLE, OWN_M0 and OWN_M1, recording the last granted master; with no grant the next state SHALL be IDLE.
REQ-016 Default priority: m0 SHALL win when both masters request.
REQ-017 Locked priority: m1 SHALL win if state==OWN_M1, m1_req&m1_lock, and lock_cnt<LOCK_MAX.
REQ-018 Starvation priority: m1 SHALL win if wait_cnt==MAX_WAIT and m1_req.
REQ-019 wait_cnt SHALL increment (saturating at MAX_WAIT) on each cycle m1_req is high and m1_gnt is low, and SHALL clear on m1_gnt or when m1_req is low.
REQ-020 lock_cnt SHALL increment on each m1 grant made while m1_lock is high, and SHALL clear on any cycle without an m1 grant or when m1_lock is low.
REQ-021 When lock_cnt==LOCK_MAX and m0 requests, m0 SHALL win that cycle.
REQ-022 The SRAM port SHALL be driven combinationally from the granted master: en=1, addr={addr[31:2],2'b00}-ADDR_OFFSET, wdata passed through.
REQ-023 data_sram_wen SHALL equal be when wr=1, and 4'b0000 when wr=0.
REQ-024 With no grant: en=0, wen=0, addr=0, wdata=0.
REQ-025 A granted read SHALL register rd_owner; the next cycle, exactly that master's rvalid SHALL be 1 and its rdata SHALL equal data_sram_rdata.
REQ-026 rdata SHALL be 0 when the corresponding rvalid is 0.
REQ-027 Writes SHALL produce no rvalid.
REQ-028 Back-to-back reads from alternating masters SHALL sustain one access per cycle, with every rvalid routed to the correct master.
REQ-029 Read latency SHALL be exactly 1 cycle; write completion is the grant cycle.

Reset
REQ-030 While rst=1: state=IDLE, wait_cnt=0, lock_cnt=0, rd_owner cleared, and m0_gnt=m1_gnt=0 regardless of req.
REQ-031 While rst=1: m0_rvalid=m1_rvalid=0, and the SRAM port outputs are the idle values of REQ-024.
REQ-032 A read granted in the cycle before rst asserts SHALL NOT produce rvalid after reset.

Structure
REQ-033 A shared package SHALL hold the owner-state encoding (IDLE=2'd0, OWN_M0=2'd1, OWN_M1=2'd2) and the ADDR_OFFSET default constant.
REQ-034 Priority/grant logic SHALL be one sub-module, dsram_arb_pick, which is purely combinational over the req signals, state, wait_cnt and lock_cnt.
REQ-035 The total implementation SHALL be single-clock, with no latches.

Verification
REQ-036 Reset: rst=1 for 2 cycles with both req=1 -> both gnt=0, both rvalid=0, en=0.
REQ-037 m0 read, addr=32'hA000_0104 -> same cycle: m0_gnt=1, data_sram_addr=32'h0000_0104, wen=0; next cycle: m0_rvalid=1, m0_rdata=data_sram_rdata (32'hDEAD_BEEF).
REQ-038 Starvation: both masters request continuously, m1_lock=0 -> m0 is granted 4 cycles, m1 the 5th, then the pattern repeats; no cycle has both grants high.
REQ-039 Lock: m1 holds the port with lock=1 and m0 requesting -> exactly 8 consecutive m1 grants, then m0_gnt=1.
REQ-040 m1 write, be=4'b0100, addr=32'hA000_0022, wdata=32'h5A5A_5A5A -> wen=4'b0100, data_sram_addr=32'h0000_0020, and no rvalid the next cycle.
REQ-041 Alternating reads m0, m1, m0 on consecutive cycles -> rvalid m0, m1, m0 in the following cycles; rst asserted after the last grant -> no rvalid.
